// File: rtl/fp_result_fifo_if.sv
// Producer/consumer handshake bundle for the FP mul/div result FIFO.
// The master side drives results in and accepts entries out; the slave side is the FIFO.
interface fp_result_fifo_if;
    logic        in_valid;
    logic [31:0] in_R;
    logic [4:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_R;
    logic [4:0]  out_flags;

    modport master (
        output in_valid,
        output in_R,
        output in_flags,
        output out_ready,
        input  out_valid,
        input  out_R,
        input  out_flags
    );

    modport slave (
        input  in_valid,
        input  in_R,
        input  in_flags,
        input  out_ready,
        output out_valid,
        output out_R,
        output out_flags
    );
endinterface

// File: rtl/fp_result_fifo.sv
// First-word-fall-through result FIFO behind the FP mul/div unit, with sticky
// accrued-exception flags and a saturating count of results lost on overflow.
module fp_result_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    fp_result_fifo_if.slave          bus,
    input  logic                     sticky_clr,
    output logic [4:0]               sticky_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  flags;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               out_valid_q, out_valid_d;
    entry_t             head_q, head_d;
    logic [4:0]         sticky_q, sticky_d;
    logic [DROP_W-1:0]  drop_q, drop_d;

    logic               pop_c;
    logic               push_c;
    logic               drop_c;
    entry_t             in_entry_c;

    // Handshake decode; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        in_entry_c.r     = bus.in_R;
        in_entry_c.flags = bus.in_flags;
        pop_c            = out_valid_q && bus.out_ready;
        push_c           = bus.in_valid && (!full_q || pop_c);
        drop_c           = bus.in_valid && full_q && !pop_c;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        drop_d      = drop_q;
        head_d      = '0;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        full_d      = (count_d == CNT_W'(DEPTH));
        empty_d     = (count_d == '0);
        out_valid_d = !empty_d;

        // Next head is the incoming entry only when it lands exactly at the new read slot.
        if (!empty_d) begin
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                head_d = in_entry_c;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        // Exceptions of dropped results still accrue; new flags survive a same-cycle clear.
        if (sticky_clr) begin
            sticky_d = bus.in_valid ? bus.in_flags : 5'b00000;
        end else if (bus.in_valid) begin
            sticky_d = sticky_q | bus.in_flags;
        end

        if (drop_c && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            sticky_q    <= '0;
            drop_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            sticky_q    <= sticky_d;
            drop_q      <= drop_d;
        end
    end

    // Storage array needs no reset: the registered head view masks stale slots.
    always_ff @(posedge clk) begin
        if (!arst && push_c) begin
            mem_q[wr_ptr_q] <= in_entry_c;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_R     = head_q.r;
    assign bus.out_flags = head_q.flags;
    assign sticky_flags  = sticky_q;
    assign count         = count_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_fp_result_fifo.sv
// Bench for fp_result_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fp_result_fifo;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DROP_W = 8;
    localparam int          DROP_MAX = (1 << DROP_W) - 1;

    logic                   clk = 1'b0;
    logic                   arst;
    logic                   sticky_clr;
    logic [4:0]             sticky_flags;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic [DROP_W-1:0]      drop_cnt;

    fp_result_fifo_if bus_if ();

    fp_result_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .arst         (arst),
        .bus          (bus_if),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    bit  live     = 1'b0;

    logic [36:0] mq[$];
    logic [4:0]  m_sticky = '0;
    int          m_drops  = 0;

    logic [31:0] fill_v [4];
    logic [31:0] exp_v  [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {R, flags}, evaluated at each rising edge.
    always @(posedge clk) begin : model
        bit pop, accept, dropped;
        if (arst) begin
            mq.delete();
            m_sticky = '0;
            m_drops  = 0;
        end else begin
            pop     = (mq.size() > 0) && bus_if.out_ready;
            accept  = bus_if.in_valid && ((mq.size() < DEPTH) || pop);
            dropped = bus_if.in_valid && !accept;
            if (pop) void'(mq.pop_front());
            if (accept) mq.push_back({bus_if.in_R, bus_if.in_flags});
            if (dropped && m_drops < DROP_MAX) m_drops++;
            if (sticky_clr) m_sticky = bus_if.in_valid ? bus_if.in_flags : 5'b00000;
            else if (bus_if.in_valid) m_sticky = m_sticky | bus_if.in_flags;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [36:0] h;
        if (live) begin
            h = (mq.size() > 0) ? mq[0] : 37'h0;
            chk("m_out_valid", bus_if.out_valid, mq.size() > 0);
            chk("m_out_R", bus_if.out_R, h[36:5]);
            chk("m_out_flags", bus_if.out_flags, h[4:0]);
            chk("m_count", count, mq.size());
            chk("m_full", full, mq.size() == DEPTH);
            chk("m_empty", empty, mq.size() == 0);
            chk("m_sticky", sticky_flags, m_sticky);
            chk("m_drop_cnt", drop_cnt, m_drops);
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [31:0] r,
                         input logic [4:0] f, input logic rdy, input logic clr);
        arst             = rst;
        bus_if.in_valid  = v;
        bus_if.in_R      = r;
        bus_if.in_flags  = f;
        bus_if.out_ready = rdy;
        sticky_clr       = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        fill_v[0] = 32'h3F800000;
        fill_v[1] = 32'h40000000;
        fill_v[2] = 32'h40400000;
        fill_v[3] = 32'h40800000;

        drive(1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        live = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_out_R", bus_if.out_R, 0);
        chk("rst_out_flags", bus_if.out_flags, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single entry through and out.
        drive(1'b0, 1'b1, 32'h40400000, 5'b00000, 1'b0, 1'b0);
        chk("single_valid", bus_if.out_valid, 1);
        chk("single_R", bus_if.out_R, 32'h40400000);
        chk("single_count", count, 1);
        chk("single_empty", empty, 0);
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
        chk("single_pop_empty", empty, 1);
        chk("single_pop_R", bus_if.out_R, 0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, fill_v[i], 5'h0, 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        drive(1'b0, 1'b1, 32'h40A00000, 5'h0, 1'b0, 1'b0);
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_R", bus_if.out_R, fill_v[i]);
            drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
        end
        chk("drain_empty", empty, 1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, fill_v[i], 5'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h41000000, 5'h0, 1'b1, 1'b0);
        chk("pp_count", count, 4);
        chk("pp_full", full, 1);
        chk("pp_drop", drop_cnt, 1);
        exp_v[0] = 32'h40000000;
        exp_v[1] = 32'h40400000;
        exp_v[2] = 32'h40800000;
        exp_v[3] = 32'h41000000;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain_R", bus_if.out_R, exp_v[i]);
            drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
        end
        chk("pp_drain_empty", empty, 1);

        // Three full laps of push+pop at full occupancy.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h100 + i, 5'h0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) drive(1'b0, 1'b1, 32'h200 + k, 5'h0, 1'b1, 1'b0);
        chk("wrap_count", count, 4);
        chk("wrap_drop", drop_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_drain_R", bus_if.out_R, 32'h208 + i);
            drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b1, 1'b0);
        end

        // Sticky flags accrue, clear, and survive a same-cycle clear.
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1);
        chk("sticky_pre_clr", sticky_flags, 5'b00000);
        drive(1'b0, 1'b1, 32'h1, 5'b01000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h2, 5'b00001, 1'b0, 1'b0);
        chk("sticky_accrue", sticky_flags, 5'b01001);
        chk("sticky_head_flags", bus_if.out_flags, 5'b01000);
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1);
        chk("sticky_clr", sticky_flags, 5'b00000);
        drive(1'b0, 1'b1, 32'h3, 5'b00100, 1'b0, 1'b1);
        chk("sticky_clr_in", sticky_flags, 5'b00100);

        // Drop counter saturates without wrapping.
        for (int i = 0; i < 301; i++) drive(1'b0, 1'b1, 32'h300 + i, 5'h0, 1'b0, 1'b0);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_count", count, 4);

        // Reset mid-operation discards everything, including the concurrent push.
        drive(1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h500 + i, 5'b10000, 1'b0, 1'b0);
        chk("mid_pre_count", count, 3);
        chk("mid_pre_sticky", sticky_flags, 5'b10000);
        drive(1'b1, 1'b1, 32'hDEAD0000, 5'b11111, 1'b1, 1'b1);
        chk("mid_count", count, 0);
        chk("mid_out_valid", bus_if.out_valid, 0);
        chk("mid_sticky", sticky_flags, 0);
        chk("mid_drop", drop_cnt, 0);
        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        chk("mid_after_count", count, 0);
        chk("mid_after_R", bus_if.out_R, 0);

        // Randomized traffic with varying consumer throughput.
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1000; c++) begin
                drive($urandom_range(0, 199) == 0,
                      ($urandom_range(0, 3) != 0),
                      $urandom,
                      5'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) <= ph),
                      ($urandom_range(0, 15) == 0));
            end
        end

        drive(1'b0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
